capture_controller: RTL and testbench
=====================================

// Module: capture_controller
// PURPOSE
//  Sequences sample acquisition for the logic analyzer: synchronises probe inputs,
//  paces sampling with a programmable divider, detects the trigger and fills a circular
//  sample buffer with pre-/post-trigger data. Freezes the buffer and publishes its start
//  address for the display path; in continuous mode it re-arms on frame start.
// PARAMETERS
//  CHANNEL_COUNT  10    number of probe channels (matches display channel count)
//  DEPTH          640   samples per capture (one per visible VGA column)
//  PRE_TRIG       64    samples kept before the trigger; must satisfy 0 <= PRE_TRIG < DEPTH
//  DIV_W          16    width of the sample-rate divider
// PORTS
//  clk          in   1              system clock
//  reset        in   1              asynchronous, active-high
//  chan_in      in   CHANNEL_COUNT  raw asynchronous probe inputs
//  chan_enable  in   CHANNEL_COUNT  per-channel enable; disabled channels are stored as 0
//  trig_mask    in   CHANNEL_COUNT  channels taking part in the trigger compare
//  trig_level   in   CHANNEL_COUNT  required level per masked channel
//  sample_div   in   DIV_W          sample tick every sample_div+1 clocks
//  arm          in   1              pulse: start or restart a capture
//  stop         in   1              pulse: abort to IDLE
//  continuous   in   1              re-arm automatically after each capture
//  frame_start  in   1              one-clk pulse at start of vertical blank (from VGA timing)
//  mem_we       out  1              sample buffer write strobe
//  mem_addr     out  clog2(DEPTH)   sample buffer write address
//  mem_wdata    out  CHANNEL_COUNT  sample buffer write data
//  start_addr   out  clog2(DEPTH)   buffer address of oldest sample; valid while done=1
//  done         out  1              capture complete, buffer frozen, display may read
//  busy         out  1              state is PRE, WAIT_TRIG or POST
// BEHAVIOUR
//  - Reset: state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, start_addr=0, done=0, busy=0;
//    divider, pre/post counters and sync flops cleared.
//  - chan_in passes a 2-flop synchroniser; sampled value s = sync_out & chan_enable.
//  - Tick: divider counts 0..sample_div, tick when count==sample_div, then 0;
//    sample_div=0 -> tick every clk. Divider cleared on entering PRE.
//  - Write: on a tick in PRE/WAIT_TRIG/POST, next cycle mem_we=1, mem_wdata=s,
//    mem_addr=wr_ptr; wr_ptr then increments, DEPTH-1 wraps to 0. mem_we=0 otherwise.
//  - Trigger match: ((s ^ trig_level) & trig_mask) == 0, evaluated on ticks only;
//    trig_mask=0 -> first eligible tick matches.
//  - States:
//    IDLE      -> PRE on arm.
//    PRE       write PRE_TRIG samples; -> WAIT_TRIG after the last (PRE_TRIG=0: straight on).
//    WAIT_TRIG keep writing circularly; matching tick: that sample is written, trig_ptr=its
//              address, -> POST.
//    POST      write DEPTH-PRE_TRIG-1 further samples, -> DONE after the last write.
//    DONE      start_addr=(trig_ptr-PRE_TRIG) mod DEPTH; done=1; no writes.
//              arm -> PRE; continuous=1 and frame_start=1 -> PRE.
//  - done drops the cycle the state leaves DONE; it is never high while mem_we can fire.
//  - arm in PRE/WAIT_TRIG/POST restarts at PRE: wr_ptr kept, counters cleared.
//  - stop in any state -> IDLE next clk, done=0; stop with arm same cycle: stop wins.
//  - Async reset mid-capture returns to reset values immediately; buffer contents undefined.
// STRUCTURE
//  - Shared package la_pkg: state encoding (IDLE, PRE, WAIT_TRIG, POST, DONE),
//    default DEPTH = VGA visible width, CHANNEL_COUNT default.
//  - Sub-module sample_tick_gen: 2-flop synchroniser plus divider; outputs s and tick.
//  - Sample RAM lives outside this block (dual-port: write here, read by display).
// TESTING
//  - sample_div=0, trig_mask=0, arm -> DONE after exactly DEPTH writes; start_addr=0; done=1.
//  - sample_div=3 -> mem_we pulses spaced 4 clks apart.
//  - PRE_TRIG=64, mask=0x001, level=0x001, ch0 rises on tick 200 ->
//    trig_ptr=200, start_addr=136, POST writes 575.
//  - Trigger never matches -> wr_ptr wraps 639->0, done stays 0; stop -> IDLE, mem_we=0.
//  - continuous=1 -> DONE held until frame_start; next clk busy=1, done=0.
//  - arm+stop same cycle in WAIT_TRIG -> IDLE. Reset asserted in POST -> all outputs 0 at once.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture state encoding and default geometry.
// No ports; imported by capture_controller and sample_tick_gen.
package la_pkg;

  localparam int unsigned VGA_VISIBLE_W         = 640;
  localparam int unsigned DEFAULT_DEPTH         = VGA_VISIBLE_W;
  localparam int unsigned DEFAULT_CHANNEL_COUNT = 10;
  localparam int unsigned DEFAULT_PRE_TRIG      = 64;
  localparam int unsigned DEFAULT_DIV_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_controller_sample_tick_gen.sv
// sample_tick_gen: two-flop synchroniser for the probe inputs plus the
// programmable sample-rate divider.
// Ports:
//   clk, reset       clock, async active-high reset
//   chan_in          raw asynchronous probe inputs
//   chan_enable      per-channel enable, disabled channels read as 0
//   sample_div       tick every sample_div+1 clocks
//   clear            restart the divider from 0 on the next clock
//   s                synchronised, enable-masked sample
//   tick             high on the clock where the divider reaches sample_div
module sample_tick_gen
  import la_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT,
  parameter int unsigned DIV_W         = DEFAULT_DIV_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic [CHANNEL_COUNT-1:0] chan_enable,
  input  logic [DIV_W-1:0]         sample_div,
  input  logic                     clear,
  output logic [CHANNEL_COUNT-1:0] s,
  output logic                     tick
);

  logic [CHANNEL_COUNT-1:0] sync1;
  logic [CHANNEL_COUNT-1:0] sync2;
  logic [DIV_W-1:0]         div_cnt;

  // Synchroniser and divider; the >= wrap keeps the count bounded if
  // sample_div is lowered while counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
    end else begin
      sync1 <= chan_in;
      sync2 <= sync1;
      if (clear || (div_cnt >= sample_div)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign s    = sync2 & chan_enable;
  assign tick = (div_cnt == sample_div);

endmodule

// File: rtl/capture_controller.sv
// capture_controller: sequences logic-analyzer acquisition. Paces sampling,
// fills a circular sample buffer with pre-/post-trigger data, freezes it and
// publishes the oldest-sample address for the display path.
// Ports:
//   clk, reset                 clock, async active-high reset
//   chan_in, chan_enable       probe inputs and per-channel enables
//   trig_mask, trig_level      trigger compare mask and required levels
//   sample_div                 sample tick every sample_div+1 clocks
//   arm, stop                  start/restart and abort pulses (stop wins)
//   continuous, frame_start    auto re-arm on frame start while DONE
//   mem_we, mem_addr, mem_wdata  sample buffer write port
//   start_addr, done           oldest-sample address, valid while done
//   busy                       capture in progress
module capture_controller
  import la_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT,
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned PRE_TRIG      = DEFAULT_PRE_TRIG,
  parameter int unsigned DIV_W         = DEFAULT_DIV_W,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic [CHANNEL_COUNT-1:0] chan_enable,
  input  logic [CHANNEL_COUNT-1:0] trig_mask,
  input  logic [CHANNEL_COUNT-1:0] trig_level,
  input  logic [DIV_W-1:0]         sample_div,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic                     frame_start,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [CHANNEL_COUNT-1:0] mem_wdata,
  output logic [AW-1:0]            start_addr,
  output logic                     done,
  output logic                     busy
);

  localparam int unsigned POST_N    = DEPTH - PRE_TRIG - 1;
  localparam int unsigned PRE_LAST  = (PRE_TRIG > 0) ? PRE_TRIG - 1 : 0;
  localparam int unsigned POST_LAST = (POST_N > 0) ? POST_N - 1 : 0;

  cap_state_t               state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            trig_ptr;
  logic [AW-1:0]            pre_cnt;
  logic [AW-1:0]            post_cnt;

  logic [CHANNEL_COUNT-1:0] s;
  logic                     tick;
  logic                     capturing_c;
  logic                     start_c;
  logic                     write_c;
  logic                     match_c;
  cap_state_t               arm_state_c;
  logic [AW-1:0]            wr_ptr_inc_c;
  logic [AW-1:0]            oldest_c;

  sample_tick_gen #(
    .CHANNEL_COUNT(CHANNEL_COUNT),
    .DIV_W        (DIV_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .chan_in    (chan_in),
    .chan_enable(chan_enable),
    .sample_div (sample_div),
    .clear      (start_c),
    .s          (s),
    .tick       (tick)
  );

  assign capturing_c = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  // Any (re)start of a capture; stop always overrides.
  assign start_c     = !stop && (arm || ((state == ST_DONE) && continuous && frame_start));
  // A restarting or aborting cycle does not store its sample.
  assign write_c     = capturing_c && tick && !stop && !arm;
  assign match_c     = ((s ^ trig_level) & trig_mask) == '0;
  // With no pre-trigger window the capture begins directly in WAIT_TRIG.
  assign arm_state_c = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PRE;

  assign wr_ptr_inc_c = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
  assign oldest_c     = (trig_ptr >= AW'(PRE_TRIG)) ? trig_ptr - AW'(PRE_TRIG)
                                                    : trig_ptr + AW'(DEPTH - PRE_TRIG);

  // Capture FSM with registered buffer-write and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      trig_ptr   <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      start_addr <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_we <= write_c;
      if (write_c) begin
        mem_addr  <= wr_ptr;
        mem_wdata <= s;
        wr_ptr    <= wr_ptr_inc_c;
      end

      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start_c) begin
        state    <= arm_state_c;
        pre_cnt  <= '0;
        post_cnt <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
            done <= 1'b0;
          end
          ST_PRE: begin
            if (tick) begin
              if (pre_cnt == AW'(PRE_LAST)) begin
                state <= ST_WAIT_TRIG;
              end else begin
                pre_cnt <= pre_cnt + AW'(1);
              end
            end
          end
          ST_WAIT_TRIG: begin
            if (tick && match_c) begin
              trig_ptr <= wr_ptr;
              post_cnt <= '0;
              if (POST_N == 0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (tick) begin
              if (post_cnt == AW'(POST_LAST)) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end else begin
                post_cnt <= post_cnt + AW'(1);
              end
            end
          end
          ST_DONE: begin
            // Publish one cycle after the final write so done never overlaps mem_we.
            done       <= 1'b1;
            start_addr <= oldest_c;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: directed scenarios with literal
// expectations plus a randomized phase, all checked against a
// transaction-level model of the capture rules.
module tb_capture_controller;

  localparam int unsigned CH    = 10;
  localparam int unsigned DEPTH = 640;
  localparam int unsigned PRE   = 64;
  localparam int unsigned DIVW  = 16;
  localparam int unsigned AW    = 10;
  localparam int          POSTN = DEPTH - PRE - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   chan_in, chan_enable, trig_mask, trig_level;
  logic [DIVW-1:0] sample_div;
  logic            arm, stop, continuous, frame_start;
  logic            mem_we, done, busy;
  logic [AW-1:0]   mem_addr, start_addr;
  logic [CH-1:0]   mem_wdata;

  capture_controller #(
    .CHANNEL_COUNT(CH), .DEPTH(DEPTH), .PRE_TRIG(PRE), .DIV_W(DIVW)
  ) dut (
    .clk(clk), .reset(reset), .chan_in(chan_in), .chan_enable(chan_enable),
    .trig_mask(trig_mask), .trig_level(trig_level), .sample_div(sample_div),
    .arm(arm), .stop(stop), .continuous(continuous), .frame_start(frame_start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start_addr(start_addr), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 capturing, 2 complete
  int            m_mode = 0, m_nw = 0, m_npost = 0, m_ptr = 0, m_tptr = 0, m_k = 0;
  bit            m_trig = 0;
  logic [CH-1:0] m_p1 = '0, m_p2 = '0, m_s;
  bit            m_tick, m_start, m_wr, m_was_done;
  bit            e_we = 0, e_done = 0, e_busy = 0;
  int            e_addr = 0, e_wdata = 0, e_start = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = 0; m_nw = 0; m_npost = 0; m_ptr = 0; m_tptr = 0; m_k = 0; m_trig = 0;
      m_p1 = '0; m_p2 = '0;
      e_we = 0; e_done = 0; e_busy = 0; e_addr = 0; e_wdata = 0; e_start = 0;
    end else begin
      // Sample seen now is the probe value from two clocks ago, masked by enables.
      m_s    = m_p2 & chan_enable;
      m_p2   = m_p1;
      m_p1   = chan_in;
      m_tick = ((m_k % (int'(sample_div) + 1)) == int'(sample_div));
      m_was_done = (m_mode == 2);
      m_start = !stop && (arm || (m_mode == 2 && continuous && frame_start));
      m_wr    = (m_mode == 1) && m_tick && !stop && !arm;
      e_we = m_wr;
      if (m_wr) begin
        e_addr  = m_ptr;
        e_wdata = int'(m_s);
      end
      if (stop) begin
        m_mode = 0;
      end else if (m_start) begin
        m_mode = 1; m_nw = 0; m_trig = 0; m_npost = 0;
      end else if (m_wr) begin
        if (m_nw >= PRE) begin
          if (!m_trig) begin
            if (((m_s ^ trig_level) & trig_mask) == '0) begin
              m_trig = 1;
              m_tptr = m_ptr;
              if (POSTN == 0) m_mode = 2;
            end
          end else begin
            m_npost++;
            if (m_npost == POSTN) m_mode = 2;
          end
        end
        m_nw++;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      e_done = m_was_done && (m_mode == 2);
      if (e_done) e_start = (m_tptr + DEPTH - PRE) % DEPTH;
      e_busy = (m_mode == 1);
      m_k = m_start ? 0 : m_k + 1;
    end
  end

  // ---------------- per-cycle compare and write observer ----------------
  bit cmp_en = 0;
  int obs_writes = 0, obs_first1_idx = -1, obs_first1_addr = -1, obs_last_addr = -1;
  bit obs_wrap = 0;

  initial forever begin
    @(negedge clk);
    if (!reset && cmp_en) begin
      chk("cyc_mem_we", int'(mem_we), int'(e_we));
      chk("cyc_busy", int'(busy), int'(e_busy));
      chk("cyc_done", int'(done), int'(e_done));
      if (e_we) begin
        chk("cyc_mem_addr", int'(mem_addr), e_addr);
        chk("cyc_mem_wdata", int'(mem_wdata), e_wdata);
      end
      if (e_done) chk("cyc_start_addr", int'(start_addr), e_start);
    end
    if (!reset && mem_we) begin
      if (obs_last_addr == DEPTH - 1 && mem_addr == '0) obs_wrap = 1;
      obs_last_addr = int'(mem_addr);
      if (mem_wdata[0] && obs_first1_idx < 0) begin
        obs_first1_idx  = obs_writes;
        obs_first1_addr = int'(mem_addr);
      end
      obs_writes++;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_arm();
    obs_writes = 0; obs_first1_idx = -1; obs_first1_addr = -1; obs_wrap = 0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_start_addr"}, int'(start_addr), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t[5];
    int n;
    reset = 1'b1;
    chan_in = '0; chan_enable = '1; trig_mask = '0; trig_level = '0;
    sample_div = '0; arm = 0; stop = 0; continuous = 0; frame_start = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    cmp_en = 1;
    repeat (3) @(negedge clk);

    // Immediate trigger: exactly DEPTH writes, oldest sample at address 0.
    do_arm();
    wait_done(2000, "t1_done");
    chk("t1_writes", obs_writes, 640);
    chk("t1_start_addr", int'(start_addr), 0);
    chk("t1_model_start", e_start, 0);

    // ch0 rises so that tick 200 is the first matching sample.
    trig_mask = 10'h001; trig_level = 10'h001; chan_in = '0;
    repeat (3) @(negedge clk);
    do_arm();
    repeat (198) @(negedge clk);
    chan_in = 10'h001;
    wait_done(3000, "t3_done");
    chk("t3_trig_addr", obs_first1_addr, 200);
    chk("t3_model_trig", m_tptr, 200);
    chk("t3_start_addr", int'(start_addr), 136);
    chk("t3_post_writes", obs_writes - obs_first1_idx - 1, 575);
    chk("t3_writes", obs_writes, 776);

    // Divider of 3: writes four clocks apart.
    trig_mask = '0; sample_div = 16'd3;
    do_arm();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_we && n < 5) begin
        t[n] = i;
        n++;
      end
    end
    chk("t2_nwrites", n, 5);
    for (int i = 1; i < 5; i++) chk("t2_spacing", t[i] - t[i-1], 4);
    do_stop();
    sample_div = '0;

    // No trigger ever: pointer wraps, never done; stop returns to idle.
    trig_mask = 10'h001; trig_level = 10'h001; chan_in = '0;
    repeat (3) @(negedge clk);
    do_arm();
    repeat (700) @(negedge clk);
    chk("t4_wrap", int'(obs_wrap), 1);
    chk("t4_done", int'(done), 0);
    chk("t4_busy", int'(busy), 1);
    do_stop();
    chk("t4_stop_we", int'(mem_we), 0);
    chk("t4_stop_busy", int'(busy), 0);
    @(negedge clk);
    chk("t4_idle_we", int'(mem_we), 0);

    // arm and stop together while waiting for the trigger: stop wins.
    do_arm();
    repeat (100) @(negedge clk);
    arm = 1'b1; stop = 1'b1;
    @(negedge clk);
    arm = 1'b0; stop = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_we", int'(mem_we), 0);
    @(negedge clk);
    chk("t5_busy_hold", int'(busy), 0);

    // Continuous: hold DONE until frame_start, then restart.
    trig_mask = '0; continuous = 1'b1;
    do_arm();
    wait_done(2000, "t6_done");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_done", int'(done), 1);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("t6_restart_busy", int'(busy), 1);
    chk("t6_restart_done", int'(done), 0);
    wait_done(2000, "t6_done2");
    continuous = 1'b0;
    do_stop();

    // Asynchronous reset in POST clears outputs at once.
    do_arm();
    repeat (100) @(negedge clk);
    chk("t7_busy_post", int'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t7_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized operation against the model.
    chan_enable = '1;
    for (int i = 0; i < 20000; i++) begin
      chan_in = CH'($urandom);
      if ($urandom_range(0, 99) == 0) chan_enable = CH'($urandom) | CH'(1);
      if ($urandom_range(0, 199) == 0) begin
        trig_mask  = CH'($urandom) & CH'(7);
        trig_level = CH'($urandom);
      end
      if (m_mode != 1 && $urandom_range(0, 49) == 0) sample_div = DIVW'($urandom_range(0, 2));
      if (m_mode != 1) arm = ($urandom_range(0, 29) == 0);
      else             arm = ($urandom_range(0, 2999) == 0);
      stop = ($urandom_range(0, 3999) == 0);
      frame_start = ((i % 700) == 699);
      if ($urandom_range(0, 2999) == 0) continuous = !continuous;
      @(negedge clk);
    end
    arm = 0; stop = 0; frame_start = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
